// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller: FSM state codes,
// charge-pump gain codes and run-counter width.
package pll_ctrl_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FAST    = 3'd1,
      SLOW    = 3'd2,
      LOCKED  = 3'd3,
      RESTART = 3'd4
   } pll_state_t;

   localparam logic [1:0] GAIN_OFF = 2'd0;
   localparam logic [1:0] GAIN_LO  = 2'd1;
   localparam logic [1:0] GAIN_HI  = 2'd3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PFD / charge-pump side of the lock controller: PFD samples in, pump controls out.
interface pll_lock_ctrl_if;

   logic       up;
   logic       down;
   logic       cp_en;
   logic [1:0] cp_gain;
   logic       pfd_rst;

   modport master (input up, down, output cp_en, cp_gain, pfd_rst);
   modport slave  (output up, down, input cp_en, cp_gain, pfd_rst);

endinterface

// File: rtl/pll_lock_ctrl_run_cnt.sv
// Saturating consecutive-event counter; run is the length including the current sample.
module run_cnt
   import pll_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             hit,
   output logic [CNT_W-1:0] run
);

   logic [CNT_W-1:0] cnt;

   assign run = hit ? sat_inc(cnt) : '0;

   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else            cnt <= run;
   end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL acquisition/lock FSM: fast acquire, slow settle, lock detect and loss
// detect from consecutive PFD quiet/error runs.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned QUIET_FAST  = 16,
   parameter int unsigned LOCK_CNT    = 64,
   parameter int unsigned ERR_MAX     = 4,
   parameter int unsigned LOSS_CNT    = 8,
   parameter int unsigned ACQ_TIMEOUT = 1024
)
(
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   en,
   pll_lock_ctrl_if.master        pfd,
   output logic                   locked,
   output logic                   lock_lost,
   output logic [2:0]             state
);

   localparam logic [CNT_W-1:0] QF_TH  = CNT_W'(QUIET_FAST);
   localparam logic [CNT_W-1:0] LK_TH  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] ERR_TH = CNT_W'(ERR_MAX);
   localparam logic [CNT_W-1:0] LOS_TH = CNT_W'(LOSS_CNT);
   localparam logic [CNT_W-1:0] TO_TH  = CNT_W'(ACQ_TIMEOUT);

   pll_state_t       cur, nxt;
   logic             quiet, chg, rs_done;
   logic [CNT_W-1:0] q_run, e_run, dwell, dwell_inc;

   assign quiet     = (pfd.up == pfd.down);
   assign chg       = (nxt != cur);
   assign dwell_inc = sat_inc(dwell);
   assign state     = cur;

   run_cnt u_quiet (.clk(refclk), .rst(rst), .clr(chg), .hit(quiet),  .run(q_run));
   run_cnt u_err   (.clk(refclk), .rst(rst), .clr(chg), .hit(!quiet), .run(e_run));

   // Decisions use run lengths including the current sample, so the
   // transition lands on the same edge that takes the deciding sample.
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    if (en) nxt = FAST;
         FAST:    if (q_run >= QF_TH)         nxt = SLOW;
                  else if (dwell_inc >= TO_TH) nxt = RESTART;
         SLOW:    if (q_run >= LK_TH)         nxt = LOCKED;
                  else if (e_run >= ERR_TH)   nxt = FAST;
         LOCKED:  if (e_run >= LOS_TH)        nxt = FAST;
         RESTART: if (rs_done)                nxt = FAST;
         default: nxt = IDLE;
      endcase
      if (!en) nxt = IDLE;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         cur         <= IDLE;
         dwell       <= '0;
         rs_done     <= 1'b0;
         pfd.cp_en   <= 1'b0;
         pfd.cp_gain <= GAIN_OFF;
         pfd.pfd_rst <= 1'b1;
         locked      <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         cur       <= nxt;
         dwell     <= chg ? '0 : ((cur == FAST) ? dwell_inc : dwell);
         rs_done   <= !chg && (cur == RESTART);
         lock_lost <= (cur == LOCKED) && (nxt == FAST);
         locked    <= (nxt == LOCKED);
         case (nxt)
            FAST: begin
               pfd.cp_en   <= 1'b1;
               pfd.cp_gain <= GAIN_HI;
               pfd.pfd_rst <= 1'b0;
            end
            SLOW, LOCKED: begin
               pfd.cp_en   <= 1'b1;
               pfd.cp_gain <= GAIN_LO;
               pfd.pfd_rst <= 1'b0;
            end
            default: begin
               pfd.cp_en   <= 1'b0;
               pfd.cp_gain <= GAIN_OFF;
               pfd.pfd_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: expected output words are queued per step
// and popped against the DUT one cycle later.
module tb_pll_lock_ctrl;

   typedef struct packed {
      logic [2:0] st;
      logic       cp_en;
      logic [1:0] gain;
      logic       pfd_rst;
      logic       locked;
      logic       lost;
   } obs_t;

   logic refclk, rst, en;
   logic locked, lock_lost;
   logic [2:0] state;

   pll_lock_ctrl_if pif ();

   pll_lock_ctrl #(
      .QUIET_FAST  (16),
      .LOCK_CNT    (64),
      .ERR_MAX     (4),
      .LOSS_CNT    (8),
      .ACQ_TIMEOUT (1024)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .en        (en),
      .pfd       (pif),
      .locked    (locked),
      .lock_lost (lock_lost),
      .state     (state)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   obs_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic obs_t mk(input logic [2:0] st, input logic lost);
      obs_t o;
      o.st = st;
      o.lost = lost;
      case (st)
         3'd1:    begin o.cp_en = 1'b1; o.gain = 2'd3; o.pfd_rst = 1'b0; o.locked = 1'b0; end
         3'd2:    begin o.cp_en = 1'b1; o.gain = 2'd1; o.pfd_rst = 1'b0; o.locked = 1'b0; end
         3'd3:    begin o.cp_en = 1'b1; o.gain = 2'd1; o.pfd_rst = 1'b0; o.locked = 1'b1; end
         default: begin o.cp_en = 1'b0; o.gain = 2'd0; o.pfd_rst = 1'b1; o.locked = 1'b0; end
      endcase
      return o;
   endfunction

   task automatic step(input logic r, input logic e, input logic u, input logic d,
                       input logic [2:0] st, input logic lost, input string tag);
      obs_t got, want;
      rst = r;
      en = e;
      pif.up = u;
      pif.down = d;
      exp_q.push_back(mk(st, lost));
      @(posedge refclk);
      #1;
      got = {state, pif.cp_en, pif.cp_gain, pif.pfd_rst, locked, lock_lost};
      want = exp_q.pop_front();
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
   endtask

   task automatic run(input int n, input logic e, input logic u, input logic d,
                      input logic [2:0] st, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, e, u, d, st, 1'b0, tag);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      pif.up = 1'b0;
      pif.down = 1'b0;
      #1;
      // reset wins over en
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "reset");
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "reset_hold");

      // IDLE -> FAST, 16 quiet samples in FAST -> SLOW
      run(16, 1'b1, 1'b0, 1'b0, 3'd1, "fast_acq");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, "fast_exit");

      // SLOW: 3 err, 1 quiet, 3 err stays; 4th consecutive err -> FAST
      run(3, 1'b1, 1'b1, 1'b0, 3'd2, "slow_err3");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, "slow_quiet");
      run(3, 1'b1, 1'b0, 1'b1, 3'd2, "slow_err3b");
      step(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, "slow_err_max");

      // back to SLOW using up=down=1 quiet samples, then lock
      run(15, 1'b1, 1'b1, 1'b1, 3'd1, "fast_reacq");
      step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, "fast_exit2");
      run(63, 1'b1, 1'b0, 1'b0, 3'd2, "slow_settle");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, "lock");

      // LOCKED: quiet holds, broken error run holds, 8 up-only -> loss
      run(20, 1'b1, 1'b0, 1'b0, 3'd3, "locked_quiet");
      run(7, 1'b1, 1'b1, 1'b0, 3'd3, "locked_err7");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, "locked_break");
      run(7, 1'b1, 1'b1, 1'b0, 3'd3, "locked_err7b");
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, "loss");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, "lost_pulse_end");

      // FAST dwell timeout with alternating up/quiet -> RESTART for 2 cycles
      for (int k = 2; k <= 1023; k++)
         step(1'b0, 1'b1, logic'(k % 2 == 0), 1'b0, 3'd1, 1'b0, "fast_dwell");
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, "timeout");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, "restart_2nd");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, "restart_exit");

      // 16th quiet sample on the timeout cycle -> SLOW
      for (int k = 1; k <= 1008; k++)
         step(1'b0, 1'b1, logic'(k % 2 == 0), 1'b0, 3'd1, 1'b0, "fast_dwell2");
      run(15, 1'b1, 1'b0, 1'b0, 3'd1, "fast_quiet_run");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, "quiet_vs_timeout");

      // lock, then drop en: IDLE, no loss pulse
      run(63, 1'b1, 1'b0, 1'b0, 3'd2, "slow_settle2");
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, "lock2");
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "en_drop");
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "idle_hold");

      // reset in FAST aborts to reset values
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, "reenable");
      run(5, 1'b1, 1'b0, 1'b0, 3'd1, "fast_pre_rst");
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "rst_in_fast");
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
